playground: RTL and testbench

PLAYGROUND -- requirements
Module: playground

---
 rtl/playground.sv | 156 +++++++++++++++
 tb/tb_playground.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/playground.sv
// +----------------------------------------------------------------------------+
// | Module      : playground                                                   |
// | Description : Two push-button counters. Each raw switch is synchronized,   |
// |               debounced and release-detected. Each release increments a    |
// |               4-bit counter that drives a registered, active-low 7-segment |
// |               digit.                                                       |
// |               Optional macro PLAYGROUND_DECIMAL_EN limits both counters to |
// |               0-9 (wrap 9->0). Without it they count 0-F.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module playground #(
  parameter int DEBOUNCE_LIMIT = 8
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  output logic o_Segment1_A,
  output logic o_Segment1_B,
  output logic o_Segment1_C,
  output logic o_Segment1_D,
  output logic o_Segment1_E,
  output logic o_Segment1_F,
  output logic o_Segment1_G,
  output logic o_Segment2_A,
  output logic o_Segment2_B,
  output logic o_Segment2_C,
  output logic o_Segment2_D,
  output logic o_Segment2_E,
  output logic o_Segment2_F,
  output logic o_Segment2_G
);

  // Debounce counter must be able to hold DEBOUNCE_LIMIT-1.
  localparam int c_cnt_w = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [c_cnt_w-1:0] c_db_last = c_cnt_w'(DEBOUNCE_LIMIT - 1);

  // Digit pattern for "0" (segments A..G, active-low): held while in reset.
  localparam logic [6:0] c_seg_zero = 7'b0000001;

  // Hex to active-low 7-segment pattern, bit 6 = A ... bit 0 = G.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] lit;
    lit = 7'b0000000;
    case (value)
      4'h0: lit = 7'b1111110;
      4'h1: lit = 7'b0110000;
      4'h2: lit = 7'b1101101;
      4'h3: lit = 7'b1111001;
      4'h4: lit = 7'b0110011;
      4'h5: lit = 7'b1011011;
      4'h6: lit = 7'b1011111;
      4'h7: lit = 7'b1110000;
      4'h8: lit = 7'b1111111;
      4'h9: lit = 7'b1111011;
      4'hA: lit = 7'b1110111;
      4'hB: lit = 7'b0011111;
      4'hC: lit = 7'b1001110;
      4'hD: lit = 7'b0111101;
      4'hE: lit = 7'b1001111;
      4'hF: lit = 7'b1000111;
      default: lit = 7'b0000000;
    endcase
    return ~lit;
  endfunction

  logic [1:0] w_sw_raw;
  assign w_sw_raw = {i_Switch_2, i_Switch_1};

  // One identical channel per switch: sync -> debounce -> release -> count -> decode.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic               r_meta;
    logic               r_sync;
    logic               r_filt;
    logic               r_filt_d;
    logic [c_cnt_w-1:0] r_db_cnt;
    logic [3:0]         r_count;
    logic [6:0]         r_seg;
    logic               w_release;

    // Two-flop synchronizer for the asynchronous switch input.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        r_meta <= 1'b0;
        r_sync <= 1'b0;
      end else begin
        r_meta <= w_sw_raw[gi];
        r_sync <= r_meta;
      end
    end

    // Accept a new level only after it has differed for DEBOUNCE_LIMIT cycles.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        r_filt   <= 1'b0;
        r_db_cnt <= '0;
      end else if (r_sync != r_filt) begin
        if (r_db_cnt == c_db_last) begin
          r_filt   <= r_sync;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end

    // Delayed copy of the filtered level for falling-edge (release) detection.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        r_filt_d <= 1'b0;
      end else begin
        r_filt_d <= r_filt;
      end
    end

    assign w_release = r_filt_d & ~r_filt;

    // Count releases, wrapping at the top of the configured range.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        r_count <= 4'd0;
      end else if (w_release) begin
`ifdef PLAYGROUND_DECIMAL_EN
        if (r_count >= 4'd9) begin
          r_count <= 4'd0;
        end else begin
          r_count <= r_count + 4'd1;
        end
`else
        r_count <= r_count + 4'd1;
`endif
      end
    end

    // Registered segment decode, one cycle behind the counter.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        r_seg <= c_seg_zero;
      end else begin
        r_seg <= hex_to_seg(r_count);
      end
    end
  end

  assign {o_Segment1_A, o_Segment1_B, o_Segment1_C, o_Segment1_D,
          o_Segment1_E, o_Segment1_F, o_Segment1_G} = g_chan[0].r_seg;
  assign {o_Segment2_A, o_Segment2_B, o_Segment2_C, o_Segment2_D,
          o_Segment2_E, o_Segment2_F, o_Segment2_G} = g_chan[1].r_seg;

endmodule

`default_nettype wire

// File: tb/tb_playground.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_playground                                                |
// | Description : Randomized self-checking bench for playground. A press-count |
// |               model predicts the digit each switch should display.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_playground;

  localparam int c_limit = 8;
`ifdef PLAYGROUND_DECIMAL_EN
  localparam int c_mod = 10;
`else
  localparam int c_mod = 16;
`endif
  localparam int c_gap = 40;

  // Active-low A..G pattern of each displayed digit value.
  logic [6:0] c_digit [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic tb_clk = 1'b0;
  logic rst_n;
  logic sw1;
  logic sw2;
  logic s1a, s1b, s1c, s1d, s1e, s1f, s1g;
  logic s2a, s2b, s2c, s2d, s2e, s2f, s2g;
  logic [6:0] seg1;
  logic [6:0] seg2;

  int n_checks = 0;
  int n_pass   = 0;
  int exp1     = 0;
  int exp2     = 0;

  always #5 tb_clk = ~tb_clk;

  assign seg1 = {s1a, s1b, s1c, s1d, s1e, s1f, s1g};
  assign seg2 = {s2a, s2b, s2c, s2d, s2e, s2f, s2g};

  playground #(.DEBOUNCE_LIMIT(c_limit)) dut (
    .i_Clk       (tb_clk),
    .i_Rst_L     (rst_n),
    .i_Switch_1  (sw1),
    .i_Switch_2  (sw2),
    .o_Segment1_A(s1a), .o_Segment1_B(s1b), .o_Segment1_C(s1c), .o_Segment1_D(s1d),
    .o_Segment1_E(s1e), .o_Segment1_F(s1f), .o_Segment1_G(s1g),
    .o_Segment2_A(s2a), .o_Segment2_B(s2b), .o_Segment2_C(s2c), .o_Segment2_D(s2d),
    .o_Segment2_E(s2e), .o_Segment2_F(s2f), .o_Segment2_G(s2g)
  );

  task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge tb_clk);
  endtask

  task automatic check_both(input string tag);
    check({tag, "_d1"}, seg1, c_digit[exp1]);
    check({tag, "_d2"}, seg2, c_digit[exp2]);
  endtask

  // Drive both switches high for their own lengths from the same start cycle,
  // then a quiet gap. Presses of 12+ cycles count on release; 5 or fewer are glitches.
  task automatic press_round(input int len1, input int len2);
    int len_max;
    len_max = (len1 > len2) ? len1 : len2;
    for (int c = 0; c < len_max; c++) begin
      sw1 = (c < len1);
      sw2 = (c < len2);
      tick(1);
    end
    sw1 = 1'b0;
    sw2 = 1'b0;
    tick(c_gap);
    if (len1 >= 12) exp1 = (exp1 + 1) % c_mod;
    if (len2 >= 12) exp2 = (exp2 + 1) % c_mod;
  endtask

  function automatic int rand_len();
    int kind;
    kind = int'($urandom_range(0, 2));
    if (kind == 0) return 0;
    if (kind == 1) return int'($urandom_range(1, 5));
    return int'($urandom_range(12, 20));
  endfunction

  initial begin
    int l1;
    rst_n = 1'b0;
    sw1   = 1'b0;
    sw2   = 1'b0;
    tick(3);
    check_both("reset");

    rst_n = 1'b1;
    tick(50);
    check_both("idle");

    // Single 12-cycle press of switch 1.
    press_round(12, 0);
    check_both("single_press");

    // Repeated 3-cycle glitches must not count.
    for (int i = 0; i < 6; i++) begin
      press_round(3, 3);
    end
    check_both("glitches");

    // Holding a switch produces nothing until it is let go.
    sw1 = 1'b1;
    tick(100);
    check_both("held");
    sw1 = 1'b0;
    tick(c_gap);
    exp1 = (exp1 + 1) % c_mod;
    check_both("held_release");

    // A full cycle of switch-2 presses wraps the digit back to where it began.
    for (int i = 0; i < c_mod; i++) begin
      press_round(0, 12);
      check_both("wrap_step");
    end

    // Simultaneous releases bump both counters.
    press_round(14, 14);
    check_both("simultaneous");

    // Randomized mix of no press, glitch and real press on each switch.
    for (int i = 0; i < 30; i++) begin
      l1 = rand_len();
      press_round(l1, rand_len());
      check_both("random");
    end

    // Reset in the middle of a press clears both digits at once and the press is lost.
    press_round(12, 12);
    sw1 = 1'b1;
    tick(14);
    rst_n = 1'b0;
    #2;
    exp1 = 0;
    exp2 = 0;
    check_both("async_reset");
    tick(2);
    sw1 = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(c_gap);
    check_both("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
